// File: rtl/fetch_p1.sv
// Instruction-fetch stage: PC, instruction-memory address and IF/ID register under a run/stop machine.
// Optional FETCH_PERF_COUNTERS_EN adds fetch_count/bubble_count performance counters.
module fetch_p1 #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter logic [15:0] NOP_INSTRUCTION = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        op_halt,
    input  logic        op_pc_write,
    input  logic        op_if_id_write,
    input  logic        op_if_id_flush,
    input  logic        op_branch,
    input  logic [15:0] branch_address,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_address,
    output logic [15:0] instruction_register,
    output logic [15:0] program_counter_pre,
    output logic        if_id_valid,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic        running,
    output logic [15:0] fetch_count,
    output logic [15:0] bubble_count
`else
    output logic        running
`endif
);

    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pre_q, pre_d;
    logic        valid_q, valid_d;

    logic        run_s;
    logic        bubble_s;
    logic        load_s;
    logic        advance_s;

    assign run_s     = (state_q == ST_RUN);
    // Halt/flush wins over a load; an exec pulse in RUN pauses both PC and IF/ID.
    assign bubble_s  = run_s && (op_halt || op_if_id_flush);
    assign load_s    = run_s && !bubble_s && op_if_id_write && !exec;
    assign advance_s = run_s && !op_halt && !exec && op_pc_write;

    // Next-state logic for the run/stop machine, PC and IF/ID register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pre_d   = pre_q;
        valid_d = valid_q;

        case (state_q)
            ST_STOP: begin
                if (exec) state_d = ST_RUN;
                else      state_d = ST_STOP;
            end
            ST_RUN: begin
                if (exec || op_halt) state_d = ST_STOP;
                else                 state_d = ST_RUN;
            end
            default: state_d = ST_STOP;
        endcase

        if (advance_s) begin
            if (op_branch) pc_d = branch_address;
            else           pc_d = pc_q + 16'd1;
        end else begin
            pc_d = pc_q;
        end

        if (bubble_s) begin
            ir_d    = NOP_INSTRUCTION;
            valid_d = 1'b0;
        end else if (load_s) begin
            ir_d    = imem_data;
            pre_d   = pc_q + 16'd1;
            valid_d = 1'b1;
        end else begin
            ir_d    = ir_q;
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_STOP;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTRUCTION;
            pre_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pre_q   <= pre_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] fetch_cnt_q, bubble_cnt_q;

    // Performance counters, wrapping at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q  <= 16'h0000;
            bubble_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q  <= load_s   ? fetch_cnt_q + 16'd1  : fetch_cnt_q;
            bubble_cnt_q <= bubble_s ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

    assign imem_address         = pc_q;
    assign instruction_register = ir_q;
    assign program_counter_pre  = pre_q;
    assign if_id_valid          = valid_q;
    assign running              = run_s;

endmodule

// File: tb/tb_fetch_p1.sv
// Randomized scoreboard bench for fetch_p1 against a cycle-level behavioural model.
module tb_fetch_p1;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0000;

    logic        clock = 1'b0;
    logic        reset, exec, op_halt, op_pc_write, op_if_id_write, op_if_id_flush, op_branch;
    logic [15:0] branch_address, imem_data, imem_address, instruction_register, program_counter_pre;
    logic        if_id_valid, running;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] fetch_count, bubble_count;
`endif

    fetch_p1 #(.RESET_PC(RST_PC), .NOP_INSTRUCTION(NOP)) dut (
        .clock(clock), .reset(reset), .exec(exec), .op_halt(op_halt),
        .op_pc_write(op_pc_write), .op_if_id_write(op_if_id_write),
        .op_if_id_flush(op_if_id_flush), .op_branch(op_branch),
        .branch_address(branch_address), .imem_data(imem_data),
        .imem_address(imem_address), .instruction_register(instruction_register),
        .program_counter_pre(program_counter_pre), .if_id_valid(if_id_valid),
`ifdef FETCH_PERF_COUNTERS_EN
        .running(running), .fetch_count(fetch_count), .bubble_count(bubble_count)
`else
        .running(running)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory contents: a distinct word for every address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    assign imem_data = mem_word(imem_address);

    typedef struct packed {
        logic [15:0] pc, ir, pre, fc, bc;
        logic        v, run;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [15:0] m_pc, m_ir, m_pre, m_fc, m_bc;
    logic        m_v, m_run;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue the expected state.
    task automatic step(input logic rst, input logic ex, input logic hlt, input logic pcw,
                        input logic ifw, input logic fl, input logic br, input logic [15:0] ba);
        exp_t e;
        @(negedge clock);
        reset = rst; exec = ex; op_halt = hlt; op_pc_write = pcw; op_if_id_write = ifw;
        op_if_id_flush = fl; op_branch = br; branch_address = ba;
        if (rst) begin
            m_run = 1'b0; m_pc = RST_PC; m_ir = NOP; m_pre = 16'h0000; m_v = 1'b0;
            m_fc = 16'h0000; m_bc = 16'h0000;
        end else if (m_run) begin
            if (hlt || fl) begin
                m_ir = NOP; m_v = 1'b0; m_bc = m_bc + 16'd1;
            end else if (ifw && !ex) begin
                m_ir = mem_word(m_pc); m_pre = m_pc + 16'd1; m_v = 1'b1; m_fc = m_fc + 16'd1;
            end
            if (!hlt && !ex && pcw) m_pc = br ? ba : m_pc + 16'd1;
            m_run = !(ex || hlt);
        end else if (ex) begin
            m_run = 1'b1;
        end
        e.pc = m_pc; e.ir = m_ir; e.pre = m_pre; e.fc = m_fc; e.bc = m_bc; e.v = m_v; e.run = m_run;
        exp_q.push_back(e);
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    // Monitor: after every active edge compare DUT outputs with the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_address", imem_address, e.pc);
                chk("instruction_register", instruction_register, e.ir);
                chk("program_counter_pre", program_counter_pre, e.pre);
                chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, e.v});
                chk("running", {15'd0, running}, {15'd0, e.run});
`ifdef FETCH_PERF_COUNTERS_EN
                chk("fetch_count", fetch_count, e.fc);
                chk("bubble_count", bubble_count, e.bc);
`endif
            end
        end
    end

    initial begin
        logic ex, hlt, pcw, ifw, fl, br, rst;
        logic [15:0] ba;
        int wait_cnt;
        reset = 1'b1; exec = 1'b0; op_halt = 1'b0; op_pc_write = 1'b0; op_if_id_write = 1'b0;
        op_if_id_flush = 1'b0; op_branch = 1'b0; branch_address = 16'h0000;
        m_run = 1'b0; m_pc = RST_PC; m_ir = NOP; m_pre = 16'h0000; m_v = 1'b0;
        m_fc = 16'h0000; m_bc = 16'h0000;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Controls in STOP are ignored.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        go(5);
        // Taken branch with flush at PC=5.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020);
        go(2);
        // Two-cycle stall.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        go(2);
        // Pause and resume.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        go(2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        go(2);
        // Halt, simultaneous with exec, then resume.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        go(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        go(2);
        // Wrap from 16'hFFFF.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        go(3);
        // Reset mid-run.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            ex  = ($urandom_range(0, 11) == 0);
            hlt = ($urandom_range(0, 24) == 0);
            pcw = ($urandom_range(0, 9) != 0);
            ifw = ($urandom_range(0, 3) != 0) ? pcw : 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 7) == 0);
            br  = fl ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            ba  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            step(rst, ex, hlt, pcw, ifw, fl, br, ba);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clock);
            wait_cnt++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
